// File: rtl/instr_prefetch_queue.sv
// Instruction fetch front end: PC generation, 1-cycle imem reads, small FIFO and branch redirect.
// Define IFQ_BYPASS_EN to forward a response straight to the outputs when the queue is empty.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [7:0]               imem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [7:0]               instr_out,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic [$clog2(DEPTH):0]   instr_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_EXT = DEPTH[CNT_W:0];

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              kill_q, kill_d;

    logic [7:0]        fifo_instr_q [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q    [DEPTH];

    logic [CNT_W:0]    occupancy;
    logic              have_head;
    logic              resp;
    logic              bypass_hit;
    logic              accept;
    logic              branch;
    logic              push;
    logic              pop;

    assign have_head = (count_q != '0);
    // A killed response belongs to a request issued on the wrong path.
    assign resp      = inflight_q && !kill_q;

`ifdef IFQ_BYPASS_EN
    assign bypass_hit = !have_head && resp;
`else
    assign bypass_hit = 1'b0;
`endif

    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign imem_req  = !reset && (occupancy < DEPTH_EXT);
    assign imem_addr = fetch_pc_q;

    always_comb begin
        instr_valid = !reset && (have_head || bypass_hit);
        instr_out   = 8'h00;
        instr_pc    = '0;
        if (instr_valid) begin
            if (have_head) begin
                instr_out = fifo_instr_q[rd_ptr_q];
                instr_pc  = fifo_pc_q[rd_ptr_q];
            end else begin
                instr_out = imem_rdata;
                instr_pc  = inflight_pc_q;
            end
        end
    end

    assign instr_count = reset ? '0 : count_q;

    assign accept = instr_valid && instr_ready;
    assign branch = accept && instr_out[7];
    assign pop    = accept && have_head;
    // A bypassed instruction that is consumed immediately never enters the queue.
    assign push   = resp && !branch && !(accept && bypass_hit);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        inflight_d    = imem_req;
        inflight_pc_d = fetch_pc_q;
        kill_d        = 1'b0;

        if (branch) begin
            fetch_pc_d = ADDR_W'(instr_out[5:0]);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            kill_d     = 1'b1;
        end else begin
            if (imem_req) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            kill_q        <= kill_d;
        end
    end

    // Storage carries no reset; validity is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    assert property (@(posedge clk) disable iff (reset) count_q <= DEPTH_EXT[CNT_W-1:0]);

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction fetch front end for the 8-bit pipelined processor. It generates the 6-bit program counter, issues reads to a synchronous instruction memory with one-cycle latency, and buffers the returned instructions in a small FIFO. It presents them to the IF/ID pipeline register through a valid/ready handshake. Branches (instruction bit 7 = 1, target = bits 5:0) are resolved here when accepted downstream, and every wrong-path entry is flushed.

## Interface
- DEPTH, 4, number of queue entries (power of two, 2..8)
- ADDR_W, 6, PC / instruction-memory address width
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  read request this cycle
- imem_addr  output  ADDR_W  address of the request; equals the fetch PC
- imem_rdata  input  8  instruction for the request issued in the previous cycle
- instr_valid  output  1  instr_out/instr_pc hold a valid instruction
- instr_ready  input  1  downstream accepts the instruction this cycle
- instr_out  output  8  instruction at queue head (8'h00 when not valid)
- instr_pc  output  ADDR_W  address of instr_out (0 when not valid)
- instr_count  output  $clog2(DEPTH)+1  entries currently stored

## Operation
- State: fetch_pc, FIFO of {instr, pc} entries with rd/wr pointers and count, in-flight flag (with its PC), and a kill flag.
- Issue rule: imem_req = !reset && (count + inflight < DEPTH), evaluated on registered values. On issue, fetch_pc increments and wraps from 63 to 0. The in-flight flag and in-flight PC are set for the next cycle.
- Response: if the in-flight flag is set and kill is clear, the entry {imem_rdata, inflight_pc} is written at the tail on this edge.
- Accept: instr_valid && instr_ready pops the head. Simultaneous push and pop keep count unchanged. The FIFO cannot overflow because of the issue rule.
- Redirect: an accept with instr_out[7]=1 is a branch. In that same cycle:
  - count goes to 0 and the pointers reset.
  - The response arriving this cycle is not written.
  - fetch_pc is loaded with instr_out[5:0].
  - kill is set, which discards the response arriving next cycle from this cycle's request.
- Non-branch instructions (bit 7 = 0) never alter fetch_pc.
- A branch whose target equals its own PC loops: the same instruction is refetched indefinitely.
- Reset (any cycle, including mid-redirect or with a response pending):
  - fetch_pc=0, count=0, pointers=0, inflight=0, kill=0.
  - imem_req=0, instr_valid=0, instr_out=8'h00, instr_pc=0, instr_count=0.
  - imem_rdata is ignored during reset and in the cycle after it.

## Timing
- Request in cycle t -> data sampled in t+1 -> written at end of t+1 -> instr_valid in t+2 (no bypass).
- After reset deasserts before cycle 0: cycle 0 has imem_req=1 with addr 0, and the first instr_valid is in cycle 2.
- Branch accepted in cycle c: request for the target in c+1, target valid in c+3, so the penalty is 2 bubbles.
- Sustained throughput is 1 instruction/cycle while instr_ready is held high.
- With instr_ready low, the queue fills to DEPTH and imem_req then stays 0. Outputs hold their value until accepted.
- All outputs are registered or decoded from registered state, except bypass data (see Configuration).

## Configuration
- IFQ_BYPASS_EN defined:
  - When count=0 and a non-killed response arrives, instr_out/instr_pc are driven combinationally from imem_rdata/inflight_pc and instr_valid=1 in the same cycle.
  - If accepted, the instruction is not written; otherwise it is written normally.
  - A bypassed branch redirects exactly as above.
  - First valid after reset moves to cycle 1, and the branch penalty is 1 bubble.
- IFQ_BYPASS_EN undefined: pure registered path with the latencies given in Timing.

## Test plan
- Straight-line fetch: memory holds 8'h01..8'h0A at addr 0..9, instr_ready=1 -> instr_out 01,02,03,… with instr_pc 0,1,2,…, one per cycle from cycle 2.
- Backpressure: instr_ready=0 for 10 cycles -> instr_count reaches 4, imem_req=0 afterwards, and instr_out holds 8'h01. On release, 01..0A arrive in order with none lost or duplicated.
- Branch flush: 8'h85 at addr 2 (branch to 5), instr_ready=1 -> accepted sequence is PCs 0,1,2,5,6. Entries for PCs 3 and 4 are never presented, and PC 5 is valid 3 cycles after the 8'h85 accept.
- PC wrap: run sequential 8'h00 instructions from 0 -> imem_addr goes 62, 63, 0 and instr_pc shows 63 followed by 0.
- Reset mid-operation: assert reset for 1 cycle during a branch accept with a full queue -> next cycle instr_valid=0, instr_count=0, imem_req=0. Fetch restarts at 0, with instr_pc 0 as the first valid output.
- Bypass (IFQ_BYPASS_EN): same memory as the first scenario -> 8'h01 valid in cycle 1; branch 8'h85 gives PC 5 valid 2 cycles after the accept.
